// File: rtl/bcd_clock_counter.sv
// BCD hh:mm:ss time-of-day counter with 12/24h presentation, validated load and field adjust.
// Define CLOCK_ALARM_EN to enable the hh:mm alarm pulse; otherwise alarm_match is tied low.
module bcd_clock_counter #(
  parameter logic [23:0] RESET_TIME_BCD   = 24'h120000,
  parameter bit          MODE_24H_DEFAULT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        mode_24h,
  input  logic        load_new,
  input  logic [23:0] time_to_load_bcd,
  input  logic        load_pm,
  input  logic [1:0]  adjust_field,
  input  logic        adjust_up,
  input  logic        adjust_down,
  output logic [23:0] time_bcd,
  output logic        pm,
  output logic        minute_carry,
  output logic        hour_carry,
  output logic        day_carry,
  output logic        load_error,
  input  logic [15:0] alarm_hhmm_bcd,
  input  logic        alarm_arm,
  output logic        alarm_match
);

  localparam int unsigned FW = 8;
  localparam logic [FW-1:0] SEC_MAX = FW'(59);
  localparam logic [FW-1:0] MIN_MAX = FW'(59);
  localparam logic [FW-1:0] HR_MAX  = FW'(23);
  localparam bit unused_mode_default = MODE_24H_DEFAULT;

  function automatic logic [FW-1:0] to_bin(input logic [FW-1:0] b);
    return FW'(b[7:4]) * FW'(10) + FW'(b[3:0]);
  endfunction

  function automatic logic [FW-1:0] to_bcd(input logic [FW-1:0] x);
    logic [3:0] t;
    t = 4'(x / FW'(10));
    return {t, 4'(x - FW'(t) * FW'(10))};
  endfunction

  // Wrap-around step within one field, no carry out.
  function automatic logic [FW-1:0] step(input logic [FW-1:0] v, input logic [FW-1:0] max_v,
                                         input logic up);
    if (up) return (v == max_v) ? '0 : v + FW'(1);
    return (v == '0) ? max_v : v - FW'(1);
  endfunction

  logic [FW-1:0] hh, mm, ss;
  logic [FW-1:0] hh_b, mm_b, ss_b, hh12_b;
  logic [FW-1:0] tk_hh, tk_mm, tk_ss;
  logic [FW-1:0] ld_hb, ld_hb24, ld_hh;
  logic          ss_wrap, mm_wrap, hh_wrap;
  logic          digits_ok, ld_ok;
  logic          adj_cycle;

  assign hh_b = to_bin(hh);
  assign mm_b = to_bin(mm);
  assign ss_b = to_bin(ss);

  // Presentation: internal 24h state mapped to 12h view on demand.
  always_comb begin
    hh12_b = hh_b;
    if (hh_b == '0) hh12_b = FW'(12);
    else if (hh_b > FW'(12)) hh12_b = hh_b - FW'(12);
    time_bcd = mode_24h ? {hh, mm, ss} : {to_bcd(hh12_b), mm, ss};
    pm       = (hh_b >= FW'(12));
  end

  // Load validation and 12h-to-24h conversion.
  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (time_to_load_bcd[i*4 +: 4] > 4'd9) digits_ok = 1'b0;
    end
    ld_hb = to_bin(time_to_load_bcd[23:16]);
    ld_ok = digits_ok && (time_to_load_bcd[15:12] <= 4'd5) && (time_to_load_bcd[7:4] <= 4'd5)
            && (mode_24h ? (ld_hb <= HR_MAX) : (ld_hb >= FW'(1) && ld_hb <= FW'(12)));
    if (mode_24h)               ld_hb24 = ld_hb;
    else if (ld_hb == FW'(12))  ld_hb24 = load_pm ? FW'(12) : '0;
    else                        ld_hb24 = load_pm ? ld_hb + FW'(12) : ld_hb;
    ld_hh = to_bcd(ld_hb24);
  end

  assign ss_wrap   = (ss == 8'h59);
  assign mm_wrap   = (mm == 8'h59);
  assign hh_wrap   = (hh == 8'h23);
  assign tk_ss     = to_bcd(step(ss_b, SEC_MAX, 1'b1));
  assign tk_mm     = ss_wrap ? to_bcd(step(mm_b, MIN_MAX, 1'b1)) : mm;
  assign tk_hh     = (ss_wrap && mm_wrap) ? to_bcd(step(hh_b, HR_MAX, 1'b1)) : hh;
  assign adj_cycle = (adjust_field != 2'b00) && (adjust_up || adjust_down);

  // Priority: rst > load > adjust > tick; pulses default low every cycle.
  always_ff @(posedge clk) begin
    minute_carry <= 1'b0;
    hour_carry   <= 1'b0;
    day_carry    <= 1'b0;
    load_error   <= 1'b0;
    if (rst) begin
      {hh, mm, ss} <= RESET_TIME_BCD;
    end else if (load_new) begin
      if (ld_ok) begin
        hh <= ld_hh;
        mm <= time_to_load_bcd[15:8];
        ss <= time_to_load_bcd[7:0];
      end else begin
        load_error <= 1'b1;
      end
    end else if (adj_cycle) begin
      if (adjust_up ^ adjust_down) begin
        case (adjust_field)
          2'd1:    ss <= to_bcd(step(ss_b, SEC_MAX, adjust_up));
          2'd2:    mm <= to_bcd(step(mm_b, MIN_MAX, adjust_up));
          2'd3:    hh <= to_bcd(step(hh_b, HR_MAX, adjust_up));
          default: ;
        endcase
      end
    end else if (tick) begin
      ss           <= tk_ss;
      mm           <= tk_mm;
      hh           <= tk_hh;
      minute_carry <= ss_wrap;
      hour_carry   <= ss_wrap && mm_wrap;
      day_carry    <= ss_wrap && mm_wrap && hh_wrap;
    end
  end

`ifdef CLOCK_ALARM_EN
  // Only a tick that lands on hh:mm:00 fires the alarm.
  always_ff @(posedge clk) begin
    if (rst) alarm_match <= 1'b0;
    else     alarm_match <= !load_new && !adj_cycle && tick && alarm_arm
                            && ({tk_hh, tk_mm, tk_ss} == {alarm_hhmm_bcd, 8'h00});
  end
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_hhmm_bcd, alarm_arm};
  assign alarm_match  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_clock_counter.sv
// Self-checking bench for bcd_clock_counter; reference model keeps time as seconds-of-day.
module tb_bcd_clock_counter;

  logic        clk = 1'b0;
  logic        rst, tick, mode_24h, load_new, load_pm, adjust_up, adjust_down, alarm_arm;
  logic [23:0] time_to_load_bcd;
  logic [1:0]  adjust_field;
  logic [15:0] alarm_hhmm_bcd;
  logic [23:0] time_bcd;
  logic        pm, minute_carry, hour_carry, day_carry, load_error, alarm_match;
  logic [4:0]  pv;

  int errors = 0;
  int checks = 0;
  int model_t;

  always #5 clk = ~clk;
  assign pv = {minute_carry, hour_carry, day_carry, load_error, alarm_match};

  bcd_clock_counter dut (
    .clk(clk), .rst(rst), .tick(tick), .mode_24h(mode_24h), .load_new(load_new),
    .time_to_load_bcd(time_to_load_bcd), .load_pm(load_pm), .adjust_field(adjust_field),
    .adjust_up(adjust_up), .adjust_down(adjust_down), .time_bcd(time_bcd), .pm(pm),
    .minute_carry(minute_carry), .hour_carry(hour_carry), .day_carry(day_carry),
    .load_error(load_error), .alarm_hhmm_bcd(alarm_hhmm_bcd), .alarm_arm(alarm_arm),
    .alarm_match(alarm_match)
  );

  function automatic logic [7:0] bcd2(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  function automatic logic [23:0] disp(input int t, input bit m24);
    int h, m, s;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    if (!m24) begin
      h = h % 12;
      if (h == 0) h = 12;
    end
    return {bcd2(h), bcd2(m), bcd2(s)};
  endfunction

  function automatic bit decode_load(input logic [23:0] v, input bit m24, input bit pmq,
                                     output int t);
    int d[6];
    int h, m, s;
    t = 0;
    for (int i = 0; i < 6; i++) begin
      d[i] = int'(v[i*4 +: 4]);
      if (d[i] > 9) return 1'b0;
    end
    h = d[5] * 10 + d[4]; m = d[3] * 10 + d[2]; s = d[1] * 10 + d[0];
    if (m > 59 || s > 59) return 1'b0;
    if (m24) begin
      if (h > 23) return 1'b0;
    end else begin
      if (h < 1 || h > 12) return 1'b0;
      h = (h % 12) + (pmq ? 12 : 0);
    end
    t = h * 3600 + m * 60 + s;
    return 1'b1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; tick = 1'b0; load_new = 1'b0; load_pm = 1'b0;
    adjust_field = 2'b00; adjust_up = 1'b0; adjust_down = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode_24h = 1'b1;
    cyc();
    rst = 1'b0;
    model_t = 12 * 3600;
    checks++; if (time_bcd !== 24'h120000) begin errors++; $display("FAIL reset_24h time=%h exp=120000", time_bcd); end
    checks++; if (pm !== 1'b1) begin errors++; $display("FAIL reset_pm_24h pm=%b exp=1", pm); end
    mode_24h = 1'b0; #1;
    checks++; if (time_bcd !== 24'h120000) begin errors++; $display("FAIL reset_12h time=%h exp=120000", time_bcd); end
    checks++; if (pm !== 1'b1) begin errors++; $display("FAIL reset_pm_12h pm=%b exp=1", pm); end
    checks++; if (pv !== 5'b00000) begin errors++; $display("FAIL reset_pulses got=%b exp=00000", pv); end
  endtask

  task automatic test_rollover();
    mode_24h = 1'b1; time_to_load_bcd = 24'h235958; load_new = 1'b1;
    cyc();
    load_new = 1'b0; tick = 1'b1;
    cyc();
    checks++; if (time_bcd !== 24'h235959) begin errors++; $display("FAIL roll_tick1 time=%h exp=235959", time_bcd); end
    checks++; if (pv !== 5'b00000) begin errors++; $display("FAIL roll_tick1_pulses got=%b exp=00000", pv); end
    cyc();
    tick = 1'b0;
    checks++; if (time_bcd !== 24'h000000) begin errors++; $display("FAIL roll_tick2 time=%h exp=000000", time_bcd); end
    checks++; if (pv !== 5'b11100) begin errors++; $display("FAIL roll_carries got=%b exp=11100", pv); end
    cyc();
    checks++; if (pv !== 5'b00000) begin errors++; $display("FAIL roll_carries_one_cycle got=%b exp=00000", pv); end
    model_t = 0;
  endtask

  task automatic test_mode();
    mode_24h = 1'b0; time_to_load_bcd = 24'h120000; load_pm = 1'b0; load_new = 1'b1;
    cyc();
    load_new = 1'b0;
    checks++; if (time_bcd !== 24'h120000 || pm !== 1'b0) begin errors++; $display("FAIL mode_12am time=%h pm=%b exp=120000/0", time_bcd, pm); end
    mode_24h = 1'b1; #1;
    checks++; if (time_bcd !== 24'h000000) begin errors++; $display("FAIL mode_switch time=%h exp=000000", time_bcd); end
    mode_24h = 1'b0; time_to_load_bcd = 24'h011530; load_pm = 1'b1; load_new = 1'b1;
    cyc();
    load_new = 1'b0; load_pm = 1'b0; mode_24h = 1'b1; #1;
    checks++; if (time_bcd !== 24'h131530 || pm !== 1'b1) begin errors++; $display("FAIL mode_12pm_load time=%h pm=%b exp=131530/1", time_bcd, pm); end
    model_t = 13 * 3600 + 15 * 60 + 30;
  endtask

  task automatic test_invalid_loads();
    logic [23:0] vals [3];
    bit          modes [3];
    vals[0] = 24'h246000; modes[0] = 1'b1;
    vals[1] = 24'h130000; modes[1] = 1'b0;
    vals[2] = 24'h0A0000; modes[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mode_24h = modes[i]; time_to_load_bcd = vals[i]; load_new = 1'b1; tick = 1'b1;
      cyc();
      load_new = 1'b0; tick = 1'b0; mode_24h = 1'b1; #1;
      checks++; if (time_bcd !== disp(model_t, 1'b1)) begin errors++; $display("FAIL bad_load_state[%0d] time=%h exp=%h", i, time_bcd, disp(model_t, 1'b1)); end
      checks++; if (pv !== 5'b00010) begin errors++; $display("FAIL bad_load_err[%0d] got=%b exp=00010", i, pv); end
      cyc();
      checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL bad_load_err_clear[%0d] got=%b exp=0", i, load_error); end
    end
  endtask

  task automatic test_adjust();
    mode_24h = 1'b1; time_to_load_bcd = 24'h105930; load_new = 1'b1;
    cyc();
    load_new = 1'b0; adjust_field = 2'b10; adjust_up = 1'b1; tick = 1'b1;
    cyc();
    checks++; if (time_bcd !== 24'h100030) begin errors++; $display("FAIL adj_up time=%h exp=100030", time_bcd); end
    checks++; if (pv !== 5'b00000) begin errors++; $display("FAIL adj_up_pulses got=%b exp=00000", pv); end
    adjust_up = 1'b0; adjust_down = 1'b1; tick = 1'b0;
    cyc();
    checks++; if (time_bcd !== 24'h105930) begin errors++; $display("FAIL adj_down time=%h exp=105930", time_bcd); end
    adjust_up = 1'b1; tick = 1'b1;
    cyc();
    checks++; if (time_bcd !== 24'h105930) begin errors++; $display("FAIL adj_both time=%h exp=105930", time_bcd); end
    idle();
    model_t = 10 * 3600 + 59 * 60 + 30;
  endtask

  task automatic test_random();
    int r, h, m, s, d, nt, at;
    logic [4:0] exp_pv;
    for (int c = 0; c < 600; c++) begin
      idle();
      r            = $urandom_range(0, 99);
      rst          = (r < 2);
      load_new     = (r >= 2 && r < 12);
      mode_24h     = 1'($urandom_range(0, 1));
      tick         = ($urandom_range(0, 3) != 0);
      adjust_field = 2'($urandom_range(0, 3));
      adjust_up    = ($urandom_range(0, 3) == 0);
      adjust_down  = ($urandom_range(0, 3) == 0);
      alarm_arm    = 1'($urandom_range(0, 1));
      at = ($urandom_range(0, 1) != 0) ? (model_t + 1) % 86400 : $urandom_range(0, 86399);
      alarm_hhmm_bcd = {bcd2(at / 3600), bcd2((at / 60) % 60)};
      if ($urandom_range(0, 1) != 0) begin
        time_to_load_bcd = 24'($urandom);
        load_pm = 1'($urandom_range(0, 1));
      end else begin
        h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(0, 59);
        load_pm = (h >= 12);
        time_to_load_bcd = {bcd2(mode_24h ? h : ((h % 12 == 0) ? 12 : h % 12)), bcd2(m), bcd2(s)};
      end
      exp_pv = 5'b00000;
      if (rst) begin
        model_t = 12 * 3600;
      end else if (load_new) begin
        if (decode_load(time_to_load_bcd, mode_24h, load_pm, nt)) model_t = nt;
        else exp_pv[1] = 1'b1;
      end else if (adjust_field != 2'b00 && (adjust_up || adjust_down)) begin
        if (adjust_up != adjust_down) begin
          h = model_t / 3600; m = (model_t / 60) % 60; s = model_t % 60;
          d = adjust_up ? 1 : -1;
          case (adjust_field)
            2'd1:    s = (s + d + 60) % 60;
            2'd2:    m = (m + d + 60) % 60;
            default: h = (h + d + 24) % 24;
          endcase
          model_t = h * 3600 + m * 60 + s;
        end
      end else if (tick) begin
        exp_pv[4] = (model_t % 60 == 59);
        exp_pv[3] = (model_t % 3600 == 3599);
        exp_pv[2] = (model_t == 86399);
        model_t = (model_t + 1) % 86400;
`ifdef CLOCK_ALARM_EN
        exp_pv[0] = alarm_arm && (model_t == at / 60 * 60);
`endif
      end
      cyc();
      checks++; if (time_bcd !== disp(model_t, mode_24h)) begin errors++; $display("FAIL rand_time[%0d] got=%h exp=%h", c, time_bcd, disp(model_t, mode_24h)); end
      checks++; if (pm !== (model_t >= 43200)) begin errors++; $display("FAIL rand_pm[%0d] got=%b exp=%b", c, pm, model_t >= 43200); end
      checks++; if (pv !== exp_pv) begin errors++; $display("FAIL rand_pulses[%0d] got=%b exp=%b", c, pv, exp_pv); end
    end
    idle();
    alarm_arm = 1'b0;
    cyc();
  endtask

  task automatic test_alarm();
    logic exp_hit;
`ifdef CLOCK_ALARM_EN
    exp_hit = 1'b1;
`else
    exp_hit = 1'b0;
`endif
    mode_24h = 1'b1; alarm_hhmm_bcd = 16'h0700; alarm_arm = 1'b1;
    time_to_load_bcd = 24'h065959; load_new = 1'b1;
    cyc();
    load_new = 1'b0;
    checks++; if (alarm_match !== 1'b0) begin errors++; $display("FAIL alarm_after_load got=%b exp=0", alarm_match); end
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    checks++; if (time_bcd !== 24'h070000 || alarm_match !== exp_hit) begin errors++; $display("FAIL alarm_tick time=%h match=%b exp=070000/%b", time_bcd, alarm_match, exp_hit); end
    cyc();
    checks++; if (alarm_match !== 1'b0) begin errors++; $display("FAIL alarm_one_cycle got=%b exp=0", alarm_match); end
    time_to_load_bcd = 24'h070000; load_new = 1'b1; tick = 1'b1;
    cyc();
    load_new = 1'b0; tick = 1'b0;
    checks++; if (alarm_match !== 1'b0) begin errors++; $display("FAIL alarm_direct_load got=%b exp=0", alarm_match); end
    alarm_arm = 1'b0; time_to_load_bcd = 24'h065959; load_new = 1'b1;
    cyc();
    load_new = 1'b0; tick = 1'b1;
    cyc();
    tick = 1'b0;
    checks++; if (alarm_match !== 1'b0) begin errors++; $display("FAIL alarm_disarmed got=%b exp=0", alarm_match); end
  endtask

  initial begin
    idle();
    mode_24h = 1'b1; time_to_load_bcd = '0; alarm_hhmm_bcd = '0; alarm_arm = 1'b0;
    model_t = 12 * 3600;
    test_reset();
    test_rollover();
    test_mode();
    test_invalid_loads();
    test_adjust();
    test_random();
    test_alarm();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
